// File: rtl/rr_encoder_16_4_pkg.sv
// Shared sizing for the 16-to-4 round-robin encoder slice.
// Latency: n/a (constants and a pure helper only).
// Backpressure: n/a.
package rr_encoder_16_4_pkg;

    localparam int RR_N = 16;
    localparam int RR_W = 4;

    // Wrapping step of a ring position (15 -> 0).
    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] pos);
        return pos + RR_W'(1);
    endfunction

endpackage

// File: rtl/decoder_4_16.sv
// Binary-to-one-hot decoder: 4-bit index to 16-bit one-hot.
// Latency: combinational.
// Backpressure: none, pure function of idx.
module decoder_4_16
    import rr_encoder_16_4_pkg::*;
(
    input  logic [RR_W-1:0] idx,
    output logic [RR_N-1:0] onehot
);

    assign onehot = RR_N'(1) << idx;

endmodule

// File: rtl/prio_enc_16_4.sv
// Fixed-priority encoder: lowest set bit of a 16-bit vector to a 4-bit index.
// Latency: combinational.
// Backpressure: none; any is low and idx is 0 when nothing is set.
module prio_enc_16_4
    import rr_encoder_16_4_pkg::*;
(
    input  logic [RR_N-1:0] vec,
    output logic [RR_W-1:0] idx,
    output logic            any
);

    assign any = |vec;

    // Scan downward so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = RR_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = RR_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_encoder_16_4.sv
// Round-robin encoder: 16 level requests reduced to one registered indexed grant.
// Latency: 1 cycle from a sampled request to out_valid.
// Backpressure: out_valid/ready; while stalled the grant and ptr hold, req ignored.
module rr_encoder_16_4
    import rr_encoder_16_4_pkg::*;
#(
    parameter int N = RR_N,
    parameter int W = RR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi,
    output logic [W-1:0] ptr
);

    generate
        if (N != (1 << W)) begin : g_bad_width
            $error("rr_encoder_16_4: N must equal 1<<W");
        end
    endgenerate

    logic [N-1:0] cand;
    logic [N-1:0] rot_cand;
    logic [W-1:0] rot_idx;
    logic         any_cand;
    logic [W-1:0] sel;
    logic [N-1:0] sel_onehot;
    logic         multi;
    logic         fire;
    logic         load;

    // The grant sitting in the output register is masked so a requester
    // still holding req during its fire cycle cannot win a second time.
    assign cand = req & ~(out_onehot & {N{out_valid}});

    // Rotate right by ptr so position ptr lands on bit 0 of the encoder.
    always_comb begin
        rot_cand = '0;
        for (int i = 0; i < N; i++) begin
            rot_cand[i] = cand[W'(i) + ptr];
        end
    end

    prio_enc_16_4 u_prio (
        .vec (rot_cand),
        .idx (rot_idx),
        .any (any_cand)
    );

    // Undo the rotation; W-bit arithmetic provides the modulo-N wrap.
    assign sel = rot_idx + ptr;

    decoder_4_16 u_dec (
        .idx    (sel),
        .onehot (sel_onehot)
    );

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(cand & (cand - N'(1)));

    assign fire = out_valid & out_ready;
    assign load = (~out_valid | out_ready) & any_cand;

    // Output stage: load replaces the grant (even while firing), fire alone empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
            ptr        <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_idx    <= sel;
            out_onehot <= sel_onehot;
            out_multi  <= multi;
            ptr        <= rr_next(sel);
        end else if (fire) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_encoder_16_4.sv
module tb_rr_encoder_16_4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [15:0] out_onehot;
    logic        out_multi;
    logic [3:0]  ptr;

    int tests = 0;
    int failed = 0;

    // reference state
    logic        m_valid = 1'b0;
    logic [3:0]  m_idx = '0;
    logic [15:0] m_onehot = '0;
    logic        m_multi = 1'b0;
    logic [3:0]  m_ptr = '0;

    rr_encoder_16_4 dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid  = 1'b0;
        m_idx    = '0;
        m_onehot = '0;
        m_multi  = 1'b0;
        m_ptr    = '0;
    endtask

    // Behavioural model: scan the ring from ptr for the first eligible requester.
    task automatic model_clock();
        logic [15:0] c;
        int          win;
        bit          found;
        if (reset) begin
            model_reset();
            return;
        end
        c = req & ~(m_valid ? m_onehot : 16'h0000);
        found = 1'b0;
        win = 0;
        for (int i = 0; i < 16; i++) begin
            if (!found && c[(int'(m_ptr) + i) % 16]) begin
                found = 1'b1;
                win = (int'(m_ptr) + i) % 16;
            end
        end
        if (found && (!m_valid || out_ready)) begin
            m_valid  = 1'b1;
            m_idx    = 4'(win);
            m_onehot = 16'(1) << win;
            m_multi  = ($countones(c) > 1);
            m_ptr    = 4'((win + 1) % 16);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Advance one clock; leaves time 1 unit after the edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = '0;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            tests++;
            if (out_valid !== 1'b0 || ptr !== 4'd0 || out_idx !== 4'd0 ||
                out_onehot !== 16'h0 || out_multi !== 1'b0) begin
                failed++;
                $display("FAIL reset_idle cyc%0d: valid=%b idx=%0d oh=%h multi=%b ptr=%0d, want all zero",
                         c, out_valid, out_idx, out_onehot, out_multi, ptr);
            end
        end
    endtask

    task automatic test_single();
        req = 16'h0010;
        out_ready = 1'b1;
        step();
        tests++;
        if ({out_valid, out_idx, out_onehot, out_multi, ptr} !== {1'b1, 4'd4, 16'h0010, 1'b0, 4'd5}) begin
            failed++;
            $display("FAIL single_grant: valid=%b idx=%0d oh=%h multi=%b ptr=%0d, want 1 4 0010 0 5",
                     out_valid, out_idx, out_onehot, out_multi, ptr);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || ptr !== 4'd5) begin
            failed++;
            $display("FAIL no_duplicate: valid=%b ptr=%0d, want 0 5", out_valid, ptr);
        end
        req = '0;
        step();
    endtask

    task automatic test_all_ones();
        do_reset();
        req = 16'hFFFF;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step();
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k % 16) || out_multi !== 1'b1 ||
                ptr !== 4'((k + 1) % 16) || out_onehot !== (16'(1) << (k % 16))) begin
                failed++;
                $display("FAIL all_ones k%0d: valid=%b idx=%0d oh=%h multi=%b ptr=%0d, want 1 %0d multi=1 ptr=%0d",
                         k, out_valid, out_idx, out_onehot, out_multi, ptr, k % 16, (k + 1) % 16);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h0010;
        out_ready = 1'b1;
        step();
        req = '0;
        step();
        tests++;
        if (ptr !== 4'd5 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL wrap_setup: ptr=%0d valid=%b, want 5 0", ptr, out_valid);
        end
        req = 16'h0009;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || ptr !== 4'd1 || out_multi !== 1'b1) begin
            failed++;
            $display("FAIL wrap_first: valid=%b idx=%0d ptr=%0d multi=%b, want 1 0 1 1",
                     out_valid, out_idx, ptr, out_multi);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 4'd3 || ptr !== 4'd4 || out_onehot !== 16'h0008) begin
            failed++;
            $display("FAIL wrap_second: valid=%b idx=%0d ptr=%0d oh=%h, want 1 3 4 0008",
                     out_valid, out_idx, ptr, out_onehot);
        end
    endtask

    task automatic test_backpressure();
        logic [26:0] hold;
        out_ready = 1'b0;
        hold = {m_valid, m_idx, m_onehot, m_multi, m_ptr};
        tests++;
        if (m_valid !== 1'b1) begin
            failed++;
            $display("FAIL bp_setup: model valid=%b, want 1", m_valid);
        end
        for (int c = 0; c < 4; c++) begin
            req = 16'($urandom);
            step();
            tests++;
            if ({out_valid, out_idx, out_onehot, out_multi, ptr} !== hold) begin
                failed++;
                $display("FAIL bp_stable cyc%0d: got %h, want %h", c,
                         {out_valid, out_idx, out_onehot, out_multi, ptr}, hold);
            end
        end
        req = 16'($urandom) | 16'h0100;
        out_ready = 1'b1;
        step();
        tests++;
        if ({out_valid, out_idx, out_onehot, out_multi, ptr} !== {m_valid, m_idx, m_onehot, m_multi, m_ptr} ||
            out_valid !== 1'b1) begin
            failed++;
            $display("FAIL bp_release: got %h, want %h", {out_valid, out_idx, out_onehot, out_multi, ptr},
                     {m_valid, m_idx, m_onehot, m_multi, m_ptr});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 16'(1) << $urandom_range(0, 15);
                default: req = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            tests++;
            if ({out_valid, out_idx, out_onehot, out_multi, ptr} !== {m_valid, m_idx, m_onehot, m_multi, m_ptr}) begin
                failed++;
                $display("FAIL random cyc%0d: valid=%b idx=%0d oh=%h multi=%b ptr=%0d, want %b %0d %h %b %0d",
                         c, out_valid, out_idx, out_onehot, out_multi, ptr,
                         m_valid, m_idx, m_onehot, m_multi, m_ptr);
            end
        end
        req = '0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_midreset();
        do_reset();
        req = 16'h0080;
        out_ready = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 4'd7 || ptr !== 4'd8) begin
            failed++;
            $display("FAIL midreset_setup: valid=%b idx=%0d ptr=%0d, want 1 7 8", out_valid, out_idx, ptr);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_idx !== 4'd0 || ptr !== 4'd0 ||
            out_onehot !== 16'h0 || out_multi !== 1'b0) begin
            failed++;
            $display("FAIL midreset_async: valid=%b idx=%0d oh=%h multi=%b ptr=%0d, want all zero",
                     out_valid, out_idx, out_onehot, out_multi, ptr);
        end
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || ptr !== 4'd0) begin
            failed++;
            $display("FAIL midreset_discard: valid=%b ptr=%0d, want 0 0", out_valid, ptr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ones();
        test_wrap();
        test_backpressure();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rr_encoder_16_4.md
# rr_encoder_16_4

Registered round-robin encoder: converts a 16-bit request vector into a 4-bit binary index plus a one-hot grant, one grant per handshake. It is the inverse companion of the 4→16 one-hot decoders in the shared tools file. The core uses it wherever several one-hot sources (issue slots, miss buffers, writeback ports) must be reduced to a single indexed winner with fair rotation and a valid/ready output stage.

## Interface
- N, 16, number of request lines (fixed at 16 for this block)
- W, 4, index width, log2(N)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  N  level request vector; bit i held high until requester i sees its grant fire
- out_valid  out  1  registered grant is present
- out_ready  in  1  consumer accepts the grant this cycle
- out_idx  out  W  binary index of granted request
- out_onehot  out  N  one-hot of granted request, equals decode of out_idx when out_valid=1
- out_multi  out  1  more than one candidate bit was set when this grant was captured
- ptr  out  W  current round-robin start position (debug/visibility)

## Operation
- fire = out_valid & out_ready; load = (~out_valid | out_ready) & |cand.
- cand = req & ~(out_onehot & {N{out_valid}}): the bit currently held in the output register is never a candidate, so a requester still asserting req during its fire cycle is not granted twice.
- Selection: first set bit of cand scanning upward from ptr, wrapping 15→0. Implemented as rotate-right by ptr, fixed-priority encode (lowest bit wins), add ptr back modulo 16.
- On load: out_valid←1, out_idx←sel, out_onehot←decode(sel), out_multi←(popcount(cand)>1), ptr←sel+1 (mod 16, 15 wraps to 0).
- On fire without load: out_valid←0; out_idx/out_onehot/out_multi hold last value (don't-care to consumer but deterministic).
- No load and no fire: all registers hold.
- Requester i treats fire & out_onehot[i] as its acknowledge and may drop req[i] the following cycle.

## Timing
- Reset values: out_valid=0, out_idx=0, out_onehot=0, out_multi=0, ptr=0.
- Latency: req rising at cycle t (sampled edge t) → out_valid=1 after edge t, i.e. 1 cycle.
- Throughput: one grant per cycle while out_ready=1 and cand≠0; fire and load in the same cycle replace the grant with no bubble.
- Backpressure: while out_valid=1 and out_ready=0, out_valid, out_idx, out_onehot, out_multi, ptr are stable regardless of req changes.
- out_valid never drops without a fire (except reset).
- req all zero: no load; after a fire out_valid falls next cycle.
- ptr advances only on load, never on fire alone.
- Reset asserted mid-stream: outputs and ptr go to reset values asynchronously; pending grant is discarded, not delivered.
- Outputs driven only from flops; no combinational path req→outputs or out_ready→outputs.

## Structure
- No shared package types needed; N and W are module parameters, with W derived check (N == 1<<W) as elaboration assertion.
- One sub-module: prio_enc_16_4 — combinational fixed-priority encoder (lowest set bit → 4-bit index, plus any-valid flag), the direct inverse of decoder_4_16; instantiated on the rotated candidate vector.
- Grant one-hot produced by existing decoder_4_16 on sel.
- Popcount>1 computed as |(cand & (cand-1)) — no adder tree.

## Test plan
- Reset release, req=16'h0000 for 5 cycles → out_valid=0, ptr=0 throughout.
- req=16'h0010, out_ready=1 → next cycle out_valid=1, out_idx=4, out_onehot=16'h0010, out_multi=0, ptr=5; req held one more cycle → no duplicate grant, out_valid=0 after.
- req=16'hFFFF held, out_ready=1 → grants 0,1,2,…,15,0 on consecutive cycles, out_multi=1 each, ptr wraps 15→0.
- ptr=5, req=16'h0009 → grant idx 0 (wrap), then idx 3; ptr 1 then 4.
- Grant held with out_ready=0 for 4 cycles while req toggles randomly → outputs bit-stable; on out_ready=1 same grant fires, next grant loaded same cycle.
- reset pulse mid-cycle with out_valid=1, out_idx=7 → out_valid=0, out_idx=0, ptr=0 before next clock edge.
